motor_ramp_ctrl: RTL and testbench

Two-channel DC motor driver: parametrised successor of the fixed-speed `motor` block. It accepts signed per-wheel duty targets and slews the applied duty toward each target at a programmable rate. On a sign change it decelerates to zero, holds a dead-time, then flips the H-bridge direction pins. Sits between the car-level FSM (which now issues targets instead of modes) and the L298-style bridge pins. It generates the PWM internally.

---
 rtl/motor_pkg.sv | 31 +++
 rtl/motor_ramp_ch.sv | 130 +++++++++++++
 rtl/motor_ramp_ctrl.sv | 89 ++++++++
 tb/tb_motor_ramp_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the ramped two-channel motor driver:
//   - H-bridge direction pin encodings
//   - per-channel FSM state type
//   - target clamp and absolute-value helpers, evaluated on int so one
//     definition serves every DUTY_W; callers size-cast the result back
// -----------------------------------------------------------------------------
package motor_pkg;

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } ch_state_t;

    // The most negative target has no positive twin in DUTY_W magnitude bits,
    // so it is pulled in by one to keep the range symmetric.
    function automatic int clamp_target(input int t, input int dw);
        int lim;
        lim = (1 << dw) - 1;
        return (t < -lim) ? -lim : t;
    endfunction

    function automatic int abs_val(input int v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/motor_ramp_ch.sv
// -----------------------------------------------------------------------------
// motor_ramp_ch
// One motor channel: slews a signed applied duty toward a clamped target,
// inserts a dead-time before reversing the H-bridge, and produces the PWM
// bit from the shared period counter.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   tick        : one-cycle ramp tick from the shared divider
//   estop       : level emergency stop, forces duty to zero
//   target      : signed duty target (DUTY_W+1 bits)
//   pc          : shared free-running PWM period counter
//   pwm         : PWM output bit
//   dir         : bridge direction pins (DIR_FWD / DIR_REV)
//   at_target   : applied duty equals clamped target (low while in DEAD)
// -----------------------------------------------------------------------------
module motor_ramp_ch
    import motor_pkg::*;
#(
    parameter int DUTY_W     = 10,
    parameter int RAMP_STEP  = 16,
    parameter int DEAD_TICKS = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     estop,
    input  logic signed [DUTY_W:0]   target,
    input  logic        [DUTY_W-1:0] pc,
    output logic                     pwm,
    output logic        [1:0]        dir,
    output logic                     at_target
);

    localparam int CNT_W = $clog2(DEAD_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic signed [DUTY_W+1:0] STEP = (DUTY_W+2)'(RAMP_STEP);

    logic signed [DUTY_W:0]   cur;
    logic signed [DUTY_W:0]   tgt;
    ch_state_t                state;
    logic        [CNT_W-1:0]  cnt;
    logic        [DUTY_W-1:0] dl;

    // One extra bit of headroom so target-minus-duty never wraps.
    logic signed [DUTY_W+1:0] cur_x, tgt_x, diff, step_t, step_z, next_t, next_z;
    logic t_zero, t_pos, t_neg, c_zero, c_pos, c_neg, same_dir, run_move;

    assign tgt = (DUTY_W+1)'(clamp_target(int'(target), DUTY_W));

    always_comb begin
        cur_x  = (DUTY_W+2)'(cur);
        tgt_x  = (DUTY_W+2)'(tgt);
        diff   = tgt_x - cur_x;
        // Step toward the target, limited to RAMP_STEP.
        step_t = (diff > STEP) ? STEP : ((diff < -STEP) ? -STEP : diff);
        // Step toward zero, limited to RAMP_STEP; lands exactly on 0, never past it.
        step_z = (cur_x > STEP) ? -STEP : ((cur_x < -STEP) ? STEP : -cur_x);
        next_t = cur_x + step_t;
        next_z = cur_x + step_z;

        t_zero   = (tgt == '0);
        t_neg    = tgt[DUTY_W];
        t_pos    = !t_zero && !t_neg;
        c_zero   = (cur == '0);
        c_neg    = cur[DUTY_W];
        c_pos    = !c_zero && !c_neg;
        same_dir = (t_pos && (dir == DIR_FWD)) || (t_neg && (dir == DIR_REV));
        // Ramp straight toward the target when no reversal is needed.
        run_move = t_zero || (c_pos && t_pos) || (c_neg && t_neg) || (c_zero && same_dir);
    end

    // The bridge sees zero drive for a full period before a flip only when
    // DEAD_TICKS ramp ticks cover at least one PWM period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= '0;
            state <= ST_RUN;
            cnt   <= '0;
            dir   <= DIR_FWD;
            dl    <= '0;
        end else begin
            // Duty copy for the compare only changes at period boundaries.
            if (&pc) begin
                dl <= DUTY_W'(abs_val(int'(cur)));
            end

            if (estop) begin
                cur   <= '0;
                state <= ST_RUN;
                cnt   <= '0;
            end else if (tick) begin
                case (state)
                    ST_RUN: begin
                        if (run_move) begin
                            cur <= (DUTY_W+1)'(next_t);
                        end else if (!c_zero) begin
                            cur <= (DUTY_W+1)'(next_z);
                        end else begin
                            state <= ST_DEAD;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    ST_DEAD: begin
                        if (t_zero || same_dir) begin
                            // Reversal no longer wanted: resume without flipping.
                            state <= ST_RUN;
                            cnt   <= '0;
                        end else if (cnt <= CNT_ONE) begin
                            dir   <= ~dir;
                            state <= ST_RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - CNT_ONE;
                        end
                    end
                    default: begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign pwm       = (pc < dl);
    assign at_target = (state == ST_RUN) && (cur == tgt);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motor_ramp_ctrl
// Two-channel ramped DC motor driver for an L298-style bridge. Holds the
// shared ramp-tick divider and PWM period counter and fans them out to one
// motor_ramp_ch per wheel.
//
// Ports
//   clk, rst            : 100 MHz clock, asynchronous active-high reset
//   l_target, r_target  : signed per-wheel duty targets (DUTY_W+1 bits)
//   estop               : level emergency stop
//   pwm                 : {left, right} PWM
//   l_IN, r_IN          : bridge direction pins, 2'b10 fwd / 2'b01 rev
//   at_target           : {left, right} applied duty equals clamped target
// -----------------------------------------------------------------------------
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int DUTY_W     = 10,
    parameter int RAMP_DIV   = 100000,
    parameter int RAMP_STEP  = 16,
    parameter int DEAD_TICKS = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [DUTY_W:0] l_target,
    input  logic signed [DUTY_W:0] r_target,
    input  logic                   estop,
    output logic [1:0]             pwm,
    output logic [1:0]             l_IN,
    output logic [1:0]             r_IN,
    output logic [1:0]             at_target
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [DUTY_W-1:0] pc;
    logic              tick;
    logic              pwm_l, pwm_r, at_l, at_r;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pc      <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            pc      <= pc + 1'b1;
        end
    end

    motor_ramp_ch #(
        .DUTY_W     (DUTY_W),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_left (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .estop     (estop),
        .target    (l_target),
        .pc        (pc),
        .pwm       (pwm_l),
        .dir       (l_IN),
        .at_target (at_l)
    );

    motor_ramp_ch #(
        .DUTY_W     (DUTY_W),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_right (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .estop     (estop),
        .target    (r_target),
        .pc        (pc),
        .pwm       (pwm_r),
        .dir       (r_IN),
        .at_target (at_r)
    );

    assign pwm       = {pwm_l, pwm_r};
    assign at_target = {at_l, at_r};

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motor_ramp_ctrl
// Self-checking bench for motor_ramp_ctrl with DUTY_W=4, RAMP_DIV=4,
// RAMP_STEP=3, DEAD_TICKS=2. Per-tick vectors are queued as they are driven
// and compared after the tick edge; estop, clamp and async reset are
// exercised as hand-written sequences.
// -----------------------------------------------------------------------------
module tb_motor_ramp_ctrl;

    localparam int DUTY_W     = 4;
    localparam int RAMP_DIV   = 4;
    localparam int RAMP_STEP  = 3;
    localparam int DEAD_TICKS = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic signed [DUTY_W:0] l_target, r_target;
    logic                   estop;
    logic [1:0]             pwm, l_IN, r_IN, at_target;

    int checks = 0;
    int errors = 0;

    // Direction encodings as ints: 2 = 2'b10 forward, 1 = 2'b01 reverse.
    typedef struct {
        int lt;
        int rt;
        int l_cur;
        int r_cur;
        int lin;
        int rin;
        int at;
    } vec_t;

    vec_t tab[21];
    vec_t ramp9[3];
    vec_t sb[$];

    always #5 clk = ~clk;

    motor_ramp_ctrl #(
        .DUTY_W     (DUTY_W),
        .RAMP_DIV   (RAMP_DIV),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_TICKS (DEAD_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .l_target  (l_target),
        .r_target  (r_target),
        .estop     (estop),
        .pwm       (pwm),
        .l_IN      (l_IN),
        .r_IN      (r_IN),
        .at_target (at_target)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait for the next ramp tick and return #1 after the edge that consumes it.
    task automatic next_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dut.tick) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        bit   ok;
        vec_t e;
        l_target = (DUTY_W+1)'(v.lt);
        r_target = (DUTY_W+1)'(v.rt);
        sb.push_back(v);
        next_tick(ok);
        check({tag, "_tick"}, int'(ok), 1);
        e = sb.pop_front();
        check({tag, "_lcur"}, int'(dut.u_left.cur), e.l_cur);
        check({tag, "_rcur"}, int'(dut.u_right.cur), e.r_cur);
        check({tag, "_lin"}, int'(l_IN), e.lin);
        check({tag, "_rin"}, int'(r_IN), e.rin);
        check({tag, "_at"}, int'(at_target), e.at);
    endtask

    task automatic count_pwm(output int cl, output int cr);
        cl = 0;
        cr = 0;
        repeat (16) begin
            @(negedge clk);
            cl += int'(pwm[1]);
            cr += int'(pwm[0]);
        end
    endtask

    initial begin
        int cl, cr, bad, misses, found;
        bit ok;

        //            lt  rt  lcur rcur lin rin at
        tab[0]  = '{10, -6,   3,   0,  2,  2,  0};   // right enters DEAD
        tab[1]  = '{10, -6,   6,   0,  2,  2,  0};
        tab[2]  = '{10, -6,   9,   0,  2,  1,  0};   // right flips
        tab[3]  = '{10, -6,  10,  -3,  2,  1,  2};
        tab[4]  = '{10, -6,  10,  -6,  2,  1,  3};
        tab[5]  = '{ 5,  0,   7,  -3,  2,  1,  0};
        tab[6]  = '{ 5,  0,   5,   0,  2,  1,  3};
        tab[7]  = '{-4,  0,   2,   0,  2,  1,  1};   // decelerate, no zero crossing
        tab[8]  = '{-4,  0,   0,   0,  2,  1,  1};
        tab[9]  = '{-4,  0,   0,   0,  2,  1,  1};   // left enters DEAD
        tab[10] = '{-4,  0,   0,   0,  2,  1,  1};
        tab[11] = '{-4,  0,   0,   0,  1,  1,  1};   // left flips on 2nd DEAD tick
        tab[12] = '{-4,  0,  -3,   0,  1,  1,  1};
        tab[13] = '{-4,  0,  -4,   0,  1,  1,  3};
        tab[14] = '{ 4,  4,  -1,   0,  1,  1,  0};   // right enters DEAD
        tab[15] = '{ 4,  4,   0,   0,  1,  1,  0};
        tab[16] = '{ 4,  0,   0,   0,  1,  1,  1};   // right aborts, left enters DEAD
        tab[17] = '{ 4,  0,   0,   0,  1,  1,  1};
        tab[18] = '{-4,  0,   0,   0,  1,  1,  1};   // left aborts, no flip
        tab[19] = '{-4,  0,  -3,   0,  1,  1,  1};
        tab[20] = '{-4,  0,  -4,   0,  1,  1,  3};

        ramp9[0] = '{9, 0, 3, 0, 2, 2, 1};
        ramp9[1] = '{9, 0, 6, 0, 2, 2, 1};
        ramp9[2] = '{9, 0, 9, 0, 2, 2, 3};

        rst      = 1'b1;
        estop    = 1'b0;
        l_target = '0;
        r_target = '0;
        repeat (2) @(negedge clk);

        check("rst_pwm", int'(pwm), 0);
        check("rst_lin", int'(l_IN), 2);
        check("rst_rin", int'(r_IN), 2);
        check("rst_at", int'(at_target), 3);
        check("rst_lcur", int'(dut.u_left.cur), 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            apply(tab[i], $sformatf("v%0d", i));
        end

        repeat (20) @(negedge clk);
        count_pwm(cl, cr);
        check("duty4_pwm_l", cl, 4);
        check("duty4_pwm_r", cr, 0);

        // estop sequence from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(ramp9[i], $sformatf("up%0d", i));
        end
        repeat (20) @(negedge clk);
        count_pwm(cl, cr);
        check("duty9_pwm_l", cl, 9);

        @(negedge clk);
        estop = 1'b1;
        @(posedge clk);
        #1;
        check("estop_lcur", int'(dut.u_left.cur), 0);
        check("estop_lin", int'(l_IN), 2);
        check("estop_at", int'(at_target), 1);
        bad = 0;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (dut.u_left.cur != '0) bad++;
            if (i >= 17 && pwm[1]) bad++;
        end
        check("estop_hold", bad, 0);
        @(negedge clk);
        estop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(ramp9[i], $sformatf("rel%0d", i));
        end

        // clamp: -16 behaves as -15, reached via DEAD and a flip
        l_target = (DUTY_W+1)'(-16);
        misses = 0;
        for (int i = 0; i < 11; i++) begin
            next_tick(ok);
            if (!ok) misses++;
        end
        check("clamp_ticks", misses, 0);
        check("clamp_lcur", int'(dut.u_left.cur), -15);
        check("clamp_lin", int'(l_IN), 1);
        check("clamp_at", int'(at_target), 3);
        next_tick(ok);
        check("clamp_hold", int'(dut.u_left.cur), -15);
        repeat (20) @(negedge clk);
        count_pwm(cl, cr);
        check("duty15_pwm_l", cl, 15);

        // async reset between clock edges while the left PWM is high
        l_target = '0;
        r_target = '0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(posedge clk);
            #2;
            if (pwm[1]) found = 1;
        end
        check("pre_rst_pwm_high", found, 1);
        rst = 1'b1;
        #1;
        check("arst_pwm", int'(pwm), 0);
        check("arst_lin", int'(l_IN), 2);
        check("arst_rin", int'(r_IN), 2);
        check("arst_at", int'(at_target), 3);
        check("arst_lcur", int'(dut.u_left.cur), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
